// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit: forwarding select codes,
// handshake state encodings and small register-match helpers.
package hazard_pkg;

    // Forwarding select codes for the execute-stage operand muxes
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Divider handshake states
    typedef enum logic {
        D_IDLE = 1'b0,
        D_BUSY = 1'b1
    } div_state_t;

    // Data-memory handshake states
    typedef enum logic {
        M_IDLE = 1'b0,
        M_WAIT = 1'b1
    } mem_state_t;

    // Generic request/acknowledge tracker states
    typedef enum logic {
        HS_IDLE = 1'b0,
        HS_BUSY = 1'b1
    } hs_state_t;

    // True when a stage that writes dst produces the value src needs; $0 never matches
    function automatic logic reg_hit(input logic wr_en, input logic [4:0] dst, input logic [4:0] src);
        return wr_en & (dst != 5'd0) & (dst == src);
    endfunction

    // Execute-stage bypass select: the youngest producer (memory stage) wins
    function automatic logic [1:0] fwd_sel(input logic rw_m, input logic [4:0] wr_m,
                                           input logic rw_w, input logic [4:0] wr_w,
                                           input logic [4:0] src);
        logic [1:0] sel_s;
        if (reg_hit(rw_m, wr_m, src)) begin
            sel_s = FWD_MEM;
        end else if (reg_hit(rw_w, wr_w, src)) begin
            sel_s = FWD_WB;
        end else begin
            sel_s = FWD_REG;
        end
        return sel_s;
    endfunction

endpackage

// File: rtl/hazard_ctrl_hs_fsm.sv
// Two-state request/acknowledge tracker. Leaves idle on launch, returns to
// idle on ack or abort. Used for both the divider and the data-memory port.
import hazard_pkg::*;

module hazard_hs_fsm (
    input  logic clk,
    input  logic rst,
    input  logic launch,
    input  logic ack,
    input  logic abort,
    output logic busy
);

    hs_state_t state_r;

    // Track whether a transaction is outstanding
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= HS_IDLE;
        end else begin
            case (state_r)
                HS_IDLE: begin
                    if (launch) begin
                        state_r <= HS_BUSY;
                    end else begin
                        state_r <= HS_IDLE;
                    end
                end
                HS_BUSY: begin
                    if (abort | ack) begin
                        state_r <= HS_IDLE;
                    end else begin
                        state_r <= HS_BUSY;
                    end
                end
                default: state_r <= HS_IDLE;
            endcase
        end
    end

    assign busy = (state_r == HS_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage MIPS pipeline: operand forwarding, load-use and
// branch stalls, divider and data-memory handshakes, exception flushes.
// Optional feature macro: HAZARD_PERF_CNT_EN enables the stalled-cycle counter;
// without it stall_cnt is held at zero and no counter flops exist.
import hazard_pkg::*;

module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       writeregE,
    input  logic [4:0]       writeregM,
    input  logic [4:0]       writeregW,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             memtoregE,
    input  logic             memtoregM,
    input  logic             branchD,
    input  logic             jrD,
    input  logic             div_instrE,
    input  logic             div_ready,
    input  logic             mem_enM,
    input  logic             data_ok,
    input  logic             exceptM,
    output logic             forwardaD,
    output logic             forwardbD,
    output logic [1:0]       forwardaE,
    output logic [1:0]       forwardbE,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             stallW,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             flushW,
    output logic             div_start,
    output logic             div_cancel,
    output logic             data_req,
    output logic [CNT_W-1:0] stall_cnt
);

    logic       div_busy_s;
    logic       mem_busy_s;
    div_state_t div_state_s;
    mem_state_t mem_state_s;
    logic       lwstall_s;
    logic       brstall_s;
    logic       div_stall_s;
    logic       mem_stall_s;
    logic       exc_s;
    logic       stall_fd_s;
    logic       stall_e_s;

    // Bypass selects for execute operands and the decode-stage branch compare
    always_comb begin
        forwardaE = fwd_sel(regwriteM, writeregM, regwriteW, writeregW, rsE);
        forwardbE = fwd_sel(regwriteM, writeregM, regwriteW, writeregW, rtE);
        forwardaD = reg_hit(regwriteM, writeregM, rsD);
        forwardbD = reg_hit(regwriteM, writeregM, rtD);
    end

    // Load-use and branch/jr operand-not-ready stalls
    always_comb begin
        lwstall_s = memtoregE & ((rtE == rsD) | (rtE == rtD));
        brstall_s = (branchD & (reg_hit(regwriteE, writeregE, rsD) | reg_hit(regwriteE, writeregE, rtD) |
                                reg_hit(memtoregM, writeregM, rsD) | reg_hit(memtoregM, writeregM, rtD)))
                  | (jrD & (reg_hit(regwriteE, writeregE, rsD) | reg_hit(memtoregM, writeregM, rsD)));
    end

    // Divider handshake: launch from idle, cancel on exception while busy
    hazard_hs_fsm u_div_fsm (
        .clk    (clk),
        .rst    (rst),
        .launch (div_instrE & ~exceptM),
        .ack    (div_ready),
        .abort  (exceptM),
        .busy   (div_busy_s)
    );

    // Memory handshake: only enters wait when the response is not same-cycle;
    // an exception never aborts an in-flight access
    hazard_hs_fsm u_mem_fsm (
        .clk    (clk),
        .rst    (rst),
        .launch (mem_enM & ~exceptM & ~data_ok),
        .ack    (data_ok),
        .abort  (1'b0),
        .busy   (mem_busy_s)
    );

    assign div_state_s = div_busy_s ? D_BUSY : D_IDLE;
    assign mem_state_s = mem_busy_s ? M_WAIT : M_IDLE;

    // Divider launch/cancel strobes and the execute-stage hold they imply
    always_comb begin
        div_start   = 1'b0;
        div_cancel  = 1'b0;
        div_stall_s = 1'b0;
        case (div_state_s)
            D_IDLE: begin
                if (div_instrE & ~exceptM) begin
                    div_start   = 1'b1;
                    div_stall_s = 1'b1;
                end else begin
                    div_start   = 1'b0;
                    div_stall_s = 1'b0;
                end
            end
            D_BUSY: begin
                if (exceptM) begin
                    div_cancel  = 1'b1;
                    div_stall_s = 1'b0;
                end else begin
                    div_cancel  = 1'b0;
                    div_stall_s = ~div_ready;
                end
            end
            default: begin
                div_start   = 1'b0;
                div_cancel  = 1'b0;
                div_stall_s = 1'b0;
            end
        endcase
    end

    // Memory request level and the pipeline hold while the response is pending
    always_comb begin
        data_req    = 1'b0;
        mem_stall_s = 1'b0;
        case (mem_state_s)
            M_IDLE: begin
                if (mem_enM & ~exceptM) begin
                    data_req    = 1'b1;
                    mem_stall_s = ~data_ok;
                end else begin
                    data_req    = 1'b0;
                    mem_stall_s = 1'b0;
                end
            end
            M_WAIT: begin
                data_req    = 1'b1;
                mem_stall_s = ~data_ok;
            end
            default: begin
                data_req    = 1'b0;
                mem_stall_s = 1'b0;
            end
        endcase
    end

    // Stall/flush combination; an exception is held off until the access completes
    always_comb begin
        exc_s      = exceptM & ~((mem_state_s == M_WAIT) & ~data_ok);
        stall_fd_s = lwstall_s | brstall_s | div_stall_s | mem_stall_s;
        stall_e_s  = div_stall_s | mem_stall_s;
        flushD     = exc_s;
        flushE     = ((lwstall_s | brstall_s) & ~stall_e_s) | exc_s;
        flushM     = (div_stall_s & ~mem_stall_s) | exc_s;
        flushW     = exc_s;
        stallF     = stall_fd_s & ~flushD;
        stallD     = stall_fd_s & ~flushD;
        stallE     = stall_e_s & ~flushE;
        stallM     = mem_stall_s & ~flushM;
        stallW     = mem_stall_s & ~flushW;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_r;

    // Count fetch-stalled cycles, wrapping naturally at the counter width
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stallF) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use and branch stalls,
// divider and memory handshakes, deferred exceptions, reset mid-transaction.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic        regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic        branchD, jrD, div_instrE, div_ready, mem_enM, data_ok, exceptM;
    logic        forwardaD, forwardbD;
    logic [1:0]  forwardaE, forwardbE;
    logic        stallF, stallD, stallE, stallM, stallW;
    logic        flushD, flushE, flushM, flushW;
    logic        div_start, div_cancel, data_req;
    logic [31:0] stall_cnt;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          fail_cnt = 0;
    logic [31:0] exp_cnt = 32'd0;
    logic        exp_stallf = 1'b0;

    hazard_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .jrD(jrD),
        .div_instrE(div_instrE), .div_ready(div_ready),
        .mem_enM(mem_enM), .data_ok(data_ok), .exceptM(exceptM),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .div_start(div_start), .div_cancel(div_cancel), .data_req(data_req),
        .stall_cnt(stall_cnt)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clr();
        rsD = 5'd0; rtD = 5'd0; rsE = 5'd0; rtE = 5'd0;
        writeregE = 5'd0; writeregM = 5'd0; writeregW = 5'd0;
        regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
        memtoregE = 1'b0; memtoregM = 1'b0; branchD = 1'b0; jrD = 1'b0;
        div_instrE = 1'b0; div_ready = 1'b0; mem_enM = 1'b0; data_ok = 1'b0; exceptM = 1'b0;
    endtask

    // st = {F,D,E,M,W}, fl = {D,E,M,W}, hs = {div_start,div_cancel,data_req},
    // fw = {forwardaE,forwardbE,forwardaD,forwardbD}
    task automatic cyc(input string tag, input logic [4:0] st, input logic [3:0] fl,
                       input logic [2:0] hs, input logic [5:0] fw);
        @(negedge clk);
        check({tag, ".stall"}, 32'({stallF, stallD, stallE, stallM, stallW}), 32'(st));
        check({tag, ".flush"}, 32'({flushD, flushE, flushM, flushW}), 32'(fl));
        check({tag, ".hs"},    32'({div_start, div_cancel, data_req}), 32'(hs));
        check({tag, ".fwd"},   32'({forwardaE, forwardbE, forwardaD, forwardbD}), 32'(fw));
`ifdef HAZARD_PERF_CNT_EN
        check({tag, ".cnt"}, stall_cnt, exp_cnt);
`else
        check({tag, ".cnt"}, stall_cnt, 32'd0);
`endif
        exp_stallf = st[4];
        @(posedge clk);
        if (rst) begin
            exp_cnt = 32'd0;
        end else if (exp_stallf) begin
            exp_cnt = exp_cnt + 32'd1;
        end else begin
            exp_cnt = exp_cnt;
        end
        #1;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        cyc("rst0", 5'b00000, 4'b0000, 3'b000, 6'b000000);
        cyc("rst1", 5'b00000, 4'b0000, 3'b000, 6'b000000);
        rst = 1'b0;
        cyc("idle", 5'b00000, 4'b0000, 3'b000, 6'b000000);

        // load-use stall for exactly one cycle
        memtoregE = 1'b1; rtE = 5'd2; rsD = 5'd2; regwriteE = 1'b1; writeregE = 5'd2;
        cyc("lw", 5'b11000, 4'b0100, 3'b000, 6'b000000);
        clr();
        cyc("lw_after", 5'b00000, 4'b0000, 3'b000, 6'b000000);

        // forwarding priorities
        rsE = 5'd5; rtE = 5'd5; rsD = 5'd5; rtD = 5'd3;
        regwriteM = 1'b1; writeregM = 5'd5; regwriteW = 1'b1; writeregW = 5'd5;
        cyc("fwd_mem", 5'b00000, 4'b0000, 3'b000, 6'b101010);
        writeregM = 5'd0;
        cyc("fwd_wb", 5'b00000, 4'b0000, 3'b000, 6'b010100);
        regwriteW = 1'b0;
        cyc("fwd_none", 5'b00000, 4'b0000, 3'b000, 6'b000000);
        regwriteW = 1'b1; writeregM = 5'd3; rtE = 5'd3;
        cyc("fwd_mix", 5'b00000, 4'b0000, 3'b000, 6'b011001);
        clr();

        // branch / jr stalls
        branchD = 1'b1; rsD = 5'd4; rtD = 5'd6; regwriteE = 1'b1; writeregE = 5'd6;
        cyc("br_rt", 5'b11000, 4'b0100, 3'b000, 6'b000000);
        branchD = 1'b0; jrD = 1'b1;
        cyc("jr_rt", 5'b00000, 4'b0000, 3'b000, 6'b000000);
        writeregE = 5'd4;
        cyc("jr_rs", 5'b11000, 4'b0100, 3'b000, 6'b000000);
        regwriteE = 1'b0; memtoregM = 1'b1; writeregM = 5'd4;
        cyc("jr_ld", 5'b11000, 4'b0100, 3'b000, 6'b000000);
        clr();
        branchD = 1'b1; regwriteE = 1'b1;
        cyc("br_r0", 5'b00000, 4'b0000, 3'b000, 6'b000000);
        clr();

        // divide: ready arrives four cycles after launch
        div_instrE = 1'b1;
        cyc("div0", 5'b11100, 4'b0010, 3'b100, 6'b000000);
        cyc("div1", 5'b11100, 4'b0010, 3'b000, 6'b000000);
        cyc("div2", 5'b11100, 4'b0010, 3'b000, 6'b000000);
        cyc("div3", 5'b11100, 4'b0010, 3'b000, 6'b000000);
        div_ready = 1'b1;
        cyc("div4", 5'b00000, 4'b0000, 3'b000, 6'b000000);
        clr();
        cyc("div5", 5'b00000, 4'b0000, 3'b000, 6'b000000);

        // exception while divider busy
        div_instrE = 1'b1;
        cyc("dx0", 5'b11100, 4'b0010, 3'b100, 6'b000000);
        exceptM = 1'b1;
        cyc("dx1", 5'b00000, 4'b1111, 3'b010, 6'b000000);
        clr();
        cyc("dx2", 5'b00000, 4'b0000, 3'b000, 6'b000000);

        // memory access, data_ok on third cycle, exception deferred
        mem_enM = 1'b1;
        cyc("mem1", 5'b11111, 4'b0000, 3'b001, 6'b000000);
        exceptM = 1'b1;
        cyc("mem2", 5'b11111, 4'b0000, 3'b001, 6'b000000);
        data_ok = 1'b1;
        cyc("mem3", 5'b00000, 4'b1111, 3'b001, 6'b000000);
        clr();
        cyc("mem4", 5'b00000, 4'b0000, 3'b000, 6'b000000);

        // same-cycle response: no stall, stays idle
        mem_enM = 1'b1; data_ok = 1'b1;
        cyc("memq0", 5'b00000, 4'b0000, 3'b001, 6'b000000);
        clr();
        cyc("memq1", 5'b00000, 4'b0000, 3'b000, 6'b000000);

        // reset in the middle of a memory wait
        mem_enM = 1'b1;
        cyc("mr1", 5'b11111, 4'b0000, 3'b001, 6'b000000);
        mem_enM = 1'b0; rst = 1'b1;
        cyc("mr2", 5'b11111, 4'b0000, 3'b001, 6'b000000);
        rst = 1'b0;
        cyc("mr3", 5'b00000, 4'b0000, 3'b000, 6'b000000);

        // a few stalls after reset so the counter restarts from zero
        memtoregE = 1'b1; rtE = 5'd7; rtD = 5'd7;
        cyc("cnt0", 5'b11000, 4'b0100, 3'b000, 6'b000000);
        cyc("cnt1", 5'b11000, 4'b0100, 3'b000, 6'b000000);
        clr();
        cyc("cnt2", 5'b00000, 4'b0000, 3'b000, 6'b000000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
